// File: rtl/adder_share_arbiter.sv
// Shares one 4-bit ripple-carry adder among four requesters.
// Each transaction runs IDLE (grant + operand latch) -> EXEC (add) -> RESP (ack).

module adder_share_arbiter_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_share_arbiter #(
    parameter int RR_ENABLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] a0,
    input  logic [3:0] a1,
    input  logic [3:0] a2,
    input  logic [3:0] a3,
    input  logic [3:0] b0,
    input  logic [3:0] b1,
    input  logic [3:0] b2,
    input  logic [3:0] b3,
    input  logic [3:0] cin,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic [3:0] ack,
    output logic [3:0] sum,
    output logic       cout,
    output logic       busy
);
    localparam int W = 4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nxt;

    logic [1:0]          ptr;
    logic [W-1:0]        op_a, op_b;
    logic                op_c;
    logic [3:0][W-1:0]   a_vec, b_vec;
    logic [1:0]          win, base, idx;
    logic                found;
    logic [W-1:0]        fa_sum;
    logic [W:0]          carry;

    assign a_vec = {a3, a2, a1, a0};
    assign b_vec = {b3, b2, b1, b0};

    // Scan from the pointer (or from 0 in fixed priority); first set bit wins.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        base  = (RR_ENABLE != 0) ? ptr : 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = base + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // The shared adder only ever sees the latched operands.
    assign carry[0] = op_c;
    for (genvar i = 0; i < W; i++) begin : g_fa
        adder_share_arbiter_fa u_fa (
            .a  (op_a[i]),
            .b  (op_b[i]),
            .ci (carry[i]),
            .s  (fa_sum[i]),
            .co (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 2'd0;
            op_a   <= '0;
            op_b   <= '0;
            op_c   <= 1'b0;
            gnt    <= 4'b0000;
            gnt_id <= 2'd0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    op_a   <= a_vec[win];
                    op_b   <= b_vec[win];
                    op_c   <= cin[win];
                    gnt_id <= win;
                    gnt    <= 4'b0001 << win;
                end
                EXEC: begin
                    sum  <= fa_sum;
                    cout <= carry[W];
                end
                RESP: begin
                    gnt <= 4'b0000;
                    if (RR_ENABLE != 0) ptr <= gnt_id + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // gnt is already one-hot, so gating it by RESP yields the ack pulse.
    assign ack  = (state == RESP) ? gnt : 4'b0000;
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: round-robin and fixed-priority
// instances share stimulus and are checked every cycle against a transaction model.

module tb_adder_share_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3, cin;

    logic [3:0] gnt_r, ack_r, sum_r, gnt_f, ack_f, sum_f;
    logic [1:0] gid_r, gid_f;
    logic       cout_r, busy_r, cout_f, busy_f;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adder_share_arbiter #(.RR_ENABLE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .cin(cin),
        .gnt(gnt_r), .gnt_id(gid_r), .ack(ack_r), .sum(sum_r), .cout(cout_r), .busy(busy_r)
    );

    adder_share_arbiter #(.RR_ENABLE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .cin(cin),
        .gnt(gnt_f), .gnt_id(gid_f), .ack(ack_f), .sum(sum_f), .cout(cout_f), .busy(busy_f)
    );

    // Transaction model, index 0 = round-robin, 1 = fixed priority.
    // ph counts cycles into the transaction: 0 idle, 1 adding, 2 responding.
    int ph[2]    = '{0, 0};
    int mw[2]    = '{0, 0};
    int mptr[2]  = '{0, 0};
    int mtot[2]  = '{0, 0};
    int msum[2]  = '{0, 0};
    int mcout[2] = '{0, 0};

    function automatic int pick(input logic [3:0] r, input int p, input bit rr);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = rr ? (p + k) % 4 : k;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    function automatic int total(input int w);
        int a, b;
        case (w)
            0: begin a = a0; b = b0; end
            1: begin a = a1; b = b1; end
            2: begin a = a2; b = b2; end
            default: begin a = a3; b = b3; end
        endcase
        return a + b + int'(cin[w]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                ph[m] <= 0; mw[m] <= 0; mptr[m] <= 0;
                mtot[m] <= 0; msum[m] <= 0; mcout[m] <= 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (ph[m] == 0) begin
                    if (req != 4'b0000) begin
                        mw[m]   <= pick(req, mptr[m], m == 0);
                        mtot[m] <= total(pick(req, mptr[m], m == 0));
                        ph[m]   <= 1;
                    end
                end else if (ph[m] == 1) begin
                    msum[m]  <= mtot[m] % 16;
                    mcout[m] <= mtot[m] / 16;
                    ph[m]    <= 2;
                end else begin
                    if (m == 0) mptr[m] <= (mw[m] + 1) % 4;
                    ph[m] <= 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string t, input int m, input logic [3:0] g, input logic [1:0] id,
                       input logic [3:0] ak, input logic [3:0] s, input logic c, input logic b);
        chk({t, ".gnt"},    int'(g),  (ph[m] != 0) ? (1 << mw[m]) : 0);
        chk({t, ".gnt_id"}, int'(id), mw[m]);
        chk({t, ".ack"},    int'(ak), (ph[m] == 2) ? (1 << mw[m]) : 0);
        chk({t, ".sum"},    int'(s),  msum[m]);
        chk({t, ".cout"},   int'(c),  mcout[m]);
        chk({t, ".busy"},   int'(b),  (ph[m] != 0) ? 1 : 0);
    endtask

    always @(negedge clk) begin
        cmp("rr", 0, gnt_r, gid_r, ack_r, sum_r, cout_r, busy_r);
        cmp("fp", 1, gnt_f, gid_f, ack_f, sum_f, cout_f, busy_f);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction starting in an IDLE cycle with req already driven.
    task automatic txn(input int rw, input int fw, input logic [3:0] drop,
                       input bit cs, input int es, input int ec);
        tick;
        chk("rr_gnt_exec", int'(gnt_r), 1 << rw);
        chk("fp_gnt_exec", int'(gnt_f), 1 << fw);
        chk("rr_ack_exec", int'(ack_r), 0);
        chk("rr_busy_exec", int'(busy_r), 1);
        tick;
        chk("rr_ack_resp", int'(ack_r), 1 << rw);
        chk("fp_ack_resp", int'(ack_f), 1 << fw);
        if (cs) begin
            chk("rr_sum", int'(sum_r), es);
            chk("rr_cout", int'(cout_r), ec);
            chk("fp_sum", int'(sum_f), es);
            chk("fp_cout", int'(cout_f), ec);
        end
        req = req & ~drop;
        tick;
        chk("rr_ack_after", int'(ack_r), 0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        rst_n = 1'b0;
        req = 4'b0000;
        {a0, a1, a2, a3, b0, b1, b2, b3, cin} = '0;
        tick; tick;
        chk("rst_gnt", int'(gnt_r), 0);
        chk("rst_ack", int'(ack_r), 0);
        chk("rst_busy", int'(busy_r), 0);
        chk("rst_sum", int'(sum_r), 0);
        rst_n = 1'b1;
        tick;

        // Single request: 3 + 4 + 1 = 8
        a1 = 4'd3; b1 = 4'd4; cin = 4'b0010; req = 4'b0010;
        txn(1, 1, 4'b0010, 1, 8, 0);
        chk("single_sum_hold", int'(sum_r), 8);
        chk("single_gid_hold", int'(gid_r), 1);

        // Round-robin fairness from PTR=0
        do_reset;
        a0 = 4'd1; b0 = 4'd2; a1 = 4'd7; b1 = 4'd9; a2 = 4'd12; b2 = 4'd5; a3 = 4'd6; b3 = 4'd10;
        cin = 4'b0101; req = 4'b1111;
        txn(0, 0, 4'b0001, 1, 4, 0);
        txn(1, 1, 4'b0010, 1, 0, 1);
        txn(2, 2, 4'b0100, 1, 2, 1);
        txn(3, 3, 4'b1000, 1, 0, 1);
        req = 4'b1001;
        txn(0, 0, 4'b0001, 0, 0, 0);
        txn(3, 3, 4'b1000, 0, 0, 0);

        // Fixed priority versus round-robin
        req = 4'b1100;
        txn(2, 2, 4'b1111, 0, 0, 0);
        req = 4'b0101;
        txn(0, 0, 4'b0001, 0, 0, 0);
        txn(2, 2, 4'b0100, 0, 0, 0);
        req = 4'b1001;
        txn(3, 0, 4'b0000, 0, 0, 0);
        txn(0, 0, 4'b1111, 0, 0, 0);

        // Carry wrap
        a3 = 4'hF; b3 = 4'hF; cin = 4'b1000; req = 4'b1000;
        txn(3, 3, 4'b1000, 1, 15, 1);
        a0 = 4'h8; b0 = 4'h8; cin = 4'b0000; req = 4'b0001;
        txn(0, 0, 4'b0001, 1, 0, 1);

        // Withdrawal during EXEC: result from latched operands 5 + 6
        a2 = 4'd5; b2 = 4'd6; cin = 4'b0000; req = 4'b0100;
        tick;
        req = 4'b0000; a2 = 4'd9;
        tick;
        chk("wd_ack_rr", int'(ack_r), 4'b0100);
        chk("wd_ack_fp", int'(ack_f), 4'b0100);
        chk("wd_sum", int'(sum_r), 11);
        chk("wd_cout", int'(cout_r), 0);
        tick;

        // Reset mid-EXEC; afterwards the round-robin scan restarts at 0
        a1 = 4'd2; b1 = 4'd2; req = 4'b0010;
        tick;
        chk("mid_gnt_pre", int'(gnt_r), 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("mid_gnt", int'(gnt_r), 0);
        chk("mid_ack", int'(ack_r), 0);
        chk("mid_sum", int'(sum_r), 0);
        chk("mid_cout", int'(cout_r), 0);
        chk("mid_busy", int'(busy_r), 0);
        req = 4'b0000;
        tick;
        rst_n = 1'b1;
        repeat (4) tick;
        req = 4'b1010;
        txn(1, 1, 4'b1010, 1, 4, 0);
        repeat (2) tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
